// File: rtl/layer_sequencer.sv
// Per-layer control FSM for the conv/pool/relu datapath: weight preload, feature stream, drain, done.
// Outputs are registered from next-state values, so state and outputs change on the same edge.
module layer_sequencer #(
  parameter int ADDR_WIDTH   = 11,
  parameter int MAX_WIDTH    = 32,
  parameter int N            = 5,
  parameter int DRAIN_CYCLES = 4,
  localparam int RC_W        = $clog2(MAX_WIDTH) + 1,
  localparam int LOC_W       = $clog2(N * N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [2:0]            cfg_mode,
  input  logic [1:0]            cfg_mux_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_weight_base,
  input  logic [ADDR_WIDTH-1:0] cfg_feat_base,
  input  logic [RC_W-1:0]       cfg_rows,
  input  logic [RC_W-1:0]       cfg_cols,
  output logic                  busy,
  output logic                  done,
  output logic                  ctrl_ram_en,
  output logic                  ctrl_addr_ctrl_en,
  output logic                  ctrl_WorI,
  output logic [2:0]            ctrl_mode,
  output logic [ADDR_WIDTH-1:0] ctrl_read_addr,
  output logic [LOC_W-1:0]      ctrl_weight_location,
  output logic [1:0]            ctrl_mux_sel
);

  localparam int CNT_W = 2 * RC_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      total_q, total_d;
  logic [ADDR_WIDTH-1:0] wbase_q, wbase_d;
  logic [ADDR_WIDTH-1:0] fbase_q, fbase_d;
  logic [2:0]            mode_q, mode_d;
  logic [1:0]            mux_q, mux_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ram_en_q, ram_en_d;
  logic                  aen_q, aen_d;
  logic                  wori_q, wori_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LOC_W-1:0]      loc_q, loc_d;

  logic start_ok;
  assign start_ok = (state_q == S_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    total_d = total_q;
    wbase_d = wbase_q;
    fbase_d = fbase_q;
    mode_d  = mode_q;
    mux_d   = mux_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          total_d = CNT_W'(cfg_rows) * CNT_W'(cfg_cols);
          wbase_d = cfg_weight_base;
          fbase_d = cfg_feat_base;
          mode_d  = cfg_mode;
          mux_d   = cfg_mux_sel;
          cnt_d   = '0;
          if (cfg_rows == '0 || cfg_cols == '0) state_d = S_DONE;
          else if (cfg_mux_sel == 2'b00)        state_d = S_LOAD_W;
          else                                  state_d = S_STREAM;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == CNT_W'(N * N - 1)) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (cnt_q == total_q - 1'b1) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    ram_en_d = (state_d == S_LOAD_W) || (state_d == S_STREAM);
    aen_d    = (state_d == S_STREAM) || (state_d == S_DRAIN);
    wori_d   = (state_d == S_LOAD_W);
    addr_d   = addr_q;
    loc_d    = loc_q;
    if (state_d == S_LOAD_W) begin
      addr_d = wbase_d + ADDR_WIDTH'(cnt_d);
      loc_d  = LOC_W'(cnt_d);
    end else if (state_d == S_STREAM) begin
      addr_d = fbase_d + ADDR_WIDTH'(cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q  <= '0;
      wbase_q  <= '0;
      fbase_q  <= '0;
      mode_q   <= '0;
      mux_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ram_en_q <= 1'b0;
      aen_q    <= 1'b0;
      wori_q   <= 1'b0;
      addr_q   <= '0;
      loc_q    <= '0;
    end else begin
      total_q  <= total_d;
      wbase_q  <= wbase_d;
      fbase_q  <= fbase_d;
      mode_q   <= mode_d;
      mux_q    <= mux_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ram_en_q <= ram_en_d;
      aen_q    <= aen_d;
      wori_q   <= wori_d;
      addr_q   <= addr_d;
      loc_q    <= loc_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign ctrl_ram_en          = ram_en_q;
  assign ctrl_addr_ctrl_en    = aen_q;
  assign ctrl_WorI            = wori_q;
  assign ctrl_mode            = mode_q;
  assign ctrl_read_addr       = addr_q;
  assign ctrl_weight_location = loc_q;
  assign ctrl_mux_sel         = mux_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: each start pushes the full expected per-cycle output
// trace; a negedge monitor pops one entry per active DUT cycle and compares.
module tb_layer_sequencer;

  localparam int AW = 11;
  localparam int RC = 6;
  localparam int NN = 25;
  localparam int DR = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [2:0]    cfg_mode = '0;
  logic [1:0]    cfg_mux_sel = '0;
  logic [AW-1:0] cfg_weight_base = '0;
  logic [AW-1:0] cfg_feat_base = '0;
  logic [RC-1:0] cfg_rows = '0;
  logic [RC-1:0] cfg_cols = '0;
  logic          busy, done, ctrl_ram_en, ctrl_addr_ctrl_en, ctrl_WorI;
  logic [2:0]    ctrl_mode;
  logic [AW-1:0] ctrl_read_addr;
  logic [4:0]    ctrl_weight_location;
  logic [1:0]    ctrl_mux_sel;

  layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_mux_sel(cfg_mux_sel),
    .cfg_weight_base(cfg_weight_base), .cfg_feat_base(cfg_feat_base),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .busy(busy), .done(done), .ctrl_ram_en(ctrl_ram_en),
    .ctrl_addr_ctrl_en(ctrl_addr_ctrl_en), .ctrl_WorI(ctrl_WorI),
    .ctrl_mode(ctrl_mode), .ctrl_read_addr(ctrl_read_addr),
    .ctrl_weight_location(ctrl_weight_location), .ctrl_mux_sel(ctrl_mux_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ram, aen, wori, dn;
    logic [AW-1:0] addr;
    logic [4:0]    loc;
    bit            chk_addr, chk_loc;
    logic [2:0]    mode;
    logic [1:0]    mux;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic exp_t mk(logic ram, logic aen, logic wori, logic dn, int addr, bit ca,
                              int loc, bit cl, logic [2:0] mode, logic [1:0] mux);
    exp_t e;
    e.ram = ram; e.aen = aen; e.wori = wori; e.dn = dn;
    e.addr = AW'(addr); e.chk_addr = ca;
    e.loc = 5'(loc); e.chk_loc = cl;
    e.mode = mode; e.mux = mux;
    return e;
  endfunction

  // Reference trace of one layer, straight from the layer rules.
  function automatic void push_layer(logic [1:0] mux, logic [2:0] mode, int wb, int fb, int r, int c);
    int total = r * c;
    if (total == 0) begin
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, mode, mux));
      return;
    end
    if (mux == 2'b00)
      for (int k = 0; k < NN; k++)
        exp_q.push_back(mk(1, 0, 1, 0, (wb + k) % 2048, 1, k, 1, mode, mux));
    for (int i = 0; i < total; i++)
      exp_q.push_back(mk(1, 1, 0, 0, (fb + i) % 2048, 1, NN - 1, mux == 2'b00, mode, mux));
    for (int d = 0; d < DR; d++)
      exp_q.push_back(mk(0, 1, 0, 0, (fb + total - 1) % 2048, 1, NN - 1, mux == 2'b00, mode, mux));
    exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, mode, mux));
  endfunction

  always @(negedge clk) begin
    if (rst_n && (busy || done || ctrl_ram_en || ctrl_addr_ctrl_en || ctrl_WorI)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_activity", {busy, done, ctrl_ram_en, ctrl_addr_ctrl_en, ctrl_WorI}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("busy", busy, 1);
        chk("ram_en", ctrl_ram_en, e.ram);
        chk("addr_ctrl_en", ctrl_addr_ctrl_en, e.aen);
        chk("WorI", ctrl_WorI, e.wori);
        chk("done", done, e.dn);
        chk("mode", ctrl_mode, e.mode);
        chk("mux_sel", ctrl_mux_sel, e.mux);
        if (e.chk_addr) chk("read_addr", ctrl_read_addr, e.addr);
        if (e.chk_loc) chk("weight_location", ctrl_weight_location, e.loc);
      end
    end
  end

  task automatic scramble_cfg();
    cfg_mode = 3'($urandom); cfg_mux_sel = 2'($urandom);
    cfg_weight_base = AW'($urandom); cfg_feat_base = AW'($urandom);
    cfg_rows = RC'($urandom); cfg_cols = RC'($urandom);
  endtask

  task automatic start_layer(input logic [1:0] mux, input logic [2:0] mode, input int wb,
                             input int fb, input int r, input int c);
    @(posedge clk); #1;
    cfg_mux_sel = mux; cfg_mode = mode; cfg_weight_base = AW'(wb); cfg_feat_base = AW'(fb);
    cfg_rows = RC'(r); cfg_cols = RC'(c);
    start = 1'b1;
    push_layer(mux, mode, wb, fb, r, c);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
  endtask

  task automatic wait_layer(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk({name, "_trace_consumed"}, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    chk({name, "_idle_busy"}, busy, 0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_enables"}, {busy, done, ctrl_ram_en, ctrl_addr_ctrl_en, ctrl_WorI}, 0);
  endtask

  initial begin
    int r, c;
    logic [1:0] m;
    #1;
    chk_quiet("reset");
    chk("reset_outputs", {ctrl_mode, ctrl_mux_sel, ctrl_read_addr, ctrl_weight_location}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    start_layer(2'b00, 3'd3, 100, 200, 3, 4);
    wait_layer("conv3x4");
    start_layer(2'b10, 3'd5, 0, 0, 2, 2);
    wait_layer("relu2x2");
    start_layer(2'b10, 3'd1, 0, 2046, 1, 4);
    wait_layer("wrap");

    // Abort during weight preload, in cycle 10.
    start_layer(2'b00, 3'd2, 300, 400, 2, 2);
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    chk_quiet("abort");
    repeat (8) @(posedge clk);
    #1 chk_quiet("after_abort");

    // Abort coincident with start wins.
    @(posedge clk); #1;
    cfg_rows = 6'd2; cfg_cols = 6'd2; cfg_mux_sel = 2'b01; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_quiet("abort_with_start");

    start_layer(2'b00, 3'd6, 500, 600, 2, 3);
    wait_layer("conv_after_abort");

    // Start while busy is ignored, then a zero-size layer.
    start_layer(2'b01, 3'd4, 0, 50, 3, 3);
    repeat (3) @(posedge clk);
    #1 cfg_cols = '0; cfg_mode = 3'd7; cfg_mux_sel = 2'b11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_layer("start_while_busy");
    start_layer(2'b00, 3'd7, 10, 20, 4, 0);
    wait_layer("zero_cols");

    for (int n = 0; n < 12; n++) begin
      m = 2'($urandom_range(0, 3));
      r = (n % 5 == 4) ? 0 : $urandom_range(1, 6);
      c = $urandom_range(1, 6);
      start_layer(m, 3'($urandom), $urandom_range(0, 2047), $urandom_range(0, 2047), r, c);
      wait_layer("random");
    end

    // Asynchronous reset during streaming.
    start_layer(2'b10, 3'd5, 0, 700, 4, 4);
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 chk_quiet("async_reset");
    chk("async_reset_cfg", {ctrl_mode, ctrl_mux_sel, ctrl_read_addr}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk_quiet("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
